// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        StStableLow,
        StQualHigh,
        StStableHigh,
        StQualLow
    } t_db_state;

    function automatic int f_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer; all stages reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_D,
    output logic o_Q
);

    logic [STAGES-1:0] r_Sync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync <= '0;
        end else begin
            r_Sync <= {r_Sync[STAGES-2:0], i_D};
        end
    end

    assign o_Q = r_Sync[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw switch pin into a stable level with one-cycle rise/fall pulses.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CntW = f_cnt_width(DEBOUNCE_LIMIT);

    logic            w_Sync;
    t_db_state       r_State;
    logic [CntW-1:0] r_Cnt;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_D    (i_Switch),
        .o_Q    (w_Sync)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State  <= StStableLow;
            r_Cnt    <= '0;
            o_Switch <= 1'b0;
            o_Rise   <= 1'b0;
            o_Fall   <= 1'b0;
        end else begin
            o_Rise <= 1'b0;
            o_Fall <= 1'b0;
            unique case (r_State)
                StStableLow: begin
                    if (w_Sync) begin
                        r_State <= StQualHigh;
                        r_Cnt   <= CntW'(1);
                    end else begin
                        r_Cnt <= '0;
                    end
                end
                StQualHigh: begin
                    if (!w_Sync) begin
                        r_State <= StStableLow;
                        r_Cnt   <= '0;
                    end else if (r_Cnt == CntW'(DEBOUNCE_LIMIT)) begin
                        r_State  <= StStableHigh;
                        r_Cnt    <= '0;
                        o_Switch <= 1'b1;
                        o_Rise   <= 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + CntW'(1);
                    end
                end
                StStableHigh: begin
                    if (!w_Sync) begin
                        r_State <= StQualLow;
                        r_Cnt   <= CntW'(1);
                    end else begin
                        r_Cnt <= '0;
                    end
                end
                StQualLow: begin
                    if (w_Sync) begin
                        r_State <= StStableHigh;
                        r_Cnt   <= '0;
                    end else if (r_Cnt == CntW'(DEBOUNCE_LIMIT)) begin
                        r_State  <= StStableLow;
                        r_Cnt    <= '0;
                        o_Switch <= 1'b0;
                        o_Fall   <= 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + CntW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce against a run-length reference model.
module tb_switch_debounce;

    localparam int LIMIT = 4;
    localparam int SYNC  = 2;

    logic i_Clk    = 1'b0;
    logic i_Rst_L  = 1'b0;
    logic i_Switch = 1'b1;
    logic o_Switch;
    logic o_Rise;
    logic o_Fall;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    switch_debounce #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Rise  (o_Rise),
        .o_Fall  (o_Fall)
    );

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // Reference: sync is the raw pin as sampled SYNC edges ago (0 until that many
    // edges since reset); a level is accepted on the (LIMIT+1)-th consecutive
    // edge at which sync differs from the accepted level.
    logic m_out  = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run  = 0;
    logic m_q[$];

    always @(posedge i_Clk or negedge i_Rst_L) begin
        logic s;
        if (!i_Rst_L) begin
            m_q.delete();
            m_out  = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            m_q.push_back(i_Switch);
            s = (m_q.size() > SYNC) ? m_q.pop_front() : 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_out) begin
                m_run++;
                if (m_run == LIMIT + 1) begin
                    m_out  = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_Clk) begin
        check_bit("model_switch", o_Switch, m_out);
        check_bit("model_rise", o_Rise, m_rise);
        check_bit("model_fall", o_Fall, m_fall);
    end

    // Returns posedges elapsed from start until the pulse is seen, -1 on timeout.
    task automatic wait_pulse(input bit want_rise, input int start, output int k);
        int guard = 0;
        logic p;
        do begin
            @(negedge i_Clk);
            guard++;
            p = want_rise ? o_Rise : o_Fall;
        end while (p !== 1'b1 && guard < 40);
        k = (p === 1'b1) ? cyc - start : -1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge i_Clk);
            if (o_Rise === 1'b1 || o_Fall === 1'b1) pulses++;
        end
    endtask

    initial begin
        int k, start, pulses, len;

        // Reset held with the pin high: outputs stay low.
        repeat (5) begin
            @(negedge i_Clk);
            check_bit("reset_switch", o_Switch, 1'b0);
            check_bit("reset_rise", o_Rise, 1'b0);
            check_bit("reset_fall", o_Fall, 1'b0);
        end
        i_Rst_L = 1'b1;
        start = cyc;
        wait_pulse(1'b1, start, k);
        check_int("release_rise_latency", k, 7);
        @(negedge i_Clk);
        check_bit("release_rise_width", o_Rise, 1'b0);
        check_bit("release_switch_high", o_Switch, 1'b1);

        // Release after press.
        repeat (3) @(negedge i_Clk);
        i_Switch = 1'b0;
        start = cyc;
        wait_pulse(1'b0, start, k);
        check_int("fall_latency", k, 7);
        @(negedge i_Clk);
        check_bit("fall_switch_low", o_Switch, 1'b0);

        // Clean press.
        repeat (3) @(negedge i_Clk);
        i_Switch = 1'b1;
        start = cyc;
        wait_pulse(1'b1, start, k);
        check_int("press_rise_latency", k, 7);
        repeat (3) @(negedge i_Clk);
        i_Switch = 1'b0;
        start = cyc;
        wait_pulse(1'b0, start, k);
        check_int("press_release_latency", k, 7);
        repeat (3) @(negedge i_Clk);

        // Bounce rejection.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            i_Switch = (i % 2 == 0);
            count_pulses(3, k);
            pulses += k;
        end
        i_Switch = 1'b0;
        count_pulses(12, k);
        pulses += k;
        check_int("bounce_pulses", pulses, 0);
        check_bit("bounce_switch", o_Switch, 1'b0);

        // Late bounce: qualification restarts from the second sync rise.
        start = cyc;
        i_Switch = 1'b1;
        repeat (3) @(negedge i_Clk);
        i_Switch = 1'b0;
        @(negedge i_Clk);
        i_Switch = 1'b1;
        wait_pulse(1'b1, start, k);
        check_int("late_bounce_latency", k, 11);
        i_Switch = 1'b0;
        start = cyc;
        wait_pulse(1'b0, start, k);
        check_int("late_bounce_fall", k, 7);
        repeat (3) @(negedge i_Clk);

        // Reset two cycles into high qualification: no stale pulse afterwards.
        i_Switch = 1'b1;
        repeat (4) @(negedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1 check_bit("midqual_reset_switch", o_Switch, 1'b0);
        i_Switch = 1'b0;
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        count_pulses(15, pulses);
        check_int("midqual_no_pulse", pulses, 0);

        // Reset while high clears the level without a clock edge.
        i_Switch = 1'b1;
        start = cyc;
        wait_pulse(1'b1, start, k);
        check_int("pre_async_rise", k, 7);
        repeat (2) @(negedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1 check_bit("async_reset_switch", o_Switch, 1'b0);
        i_Switch = 1'b0;
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (3) @(negedge i_Clk);

        // Random bouncing with occasional resets, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            i_Switch = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3) == 0) ? $urandom_range(5, 9) : $urandom_range(1, 6));
            if ($urandom_range(0, 59) == 0) begin
                #2 i_Rst_L = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge i_Clk);
                i_Rst_L = 1'b1;
            end
            repeat (len) @(negedge i_Clk);
        end
        repeat (12) @(negedge i_Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
